// File: rtl/sort_arbiter_if.sv
// ----------------------------------------------------------------------------
// sort_arbiter_if
// Handshake/bus bundle for sort_arbiter.
//   a_*/b_*   : two requesters, each sending four 4-bit signed beats plus a
//               2-bit mode (sampled on the first beat), valid/ready handshake
//   out_*     : four-beat signed 6-bit result stream tagged with its owner
//   busy      : arbiter is not idle
// Optional macro SORT_ARB_OUT_READY_EN adds out_ready (result back-pressure).
// Modports: master = requester/consumer side, slave = the arbiter.
// ----------------------------------------------------------------------------
interface sort_arbiter_if;
    logic              a_valid;
    logic signed [3:0] a_number;
    logic        [1:0] a_mode;
    logic              a_ready;

    logic              b_valid;
    logic signed [3:0] b_number;
    logic        [1:0] b_mode;
    logic              b_ready;

    logic              out_valid;
    logic signed [5:0] out_result;
    logic              out_id;
    logic              busy;
`ifdef SORT_ARB_OUT_READY_EN
    logic              out_ready;
`endif

    modport master (
        output a_valid, a_number, a_mode, b_valid, b_number, b_mode,
`ifdef SORT_ARB_OUT_READY_EN
        output out_ready,
`endif
        input  a_ready, b_ready, out_valid, out_result, out_id, busy
    );

    modport slave (
        input  a_valid, a_number, a_mode, b_valid, b_number, b_mode,
`ifdef SORT_ARB_OUT_READY_EN
        input  out_ready,
`endif
        output a_ready, b_ready, out_valid, out_result, out_id, busy
    );
endinterface

// File: rtl/sort_arbiter.sv
// ----------------------------------------------------------------------------
// sort_arbiter
// Round-robin arbiter between two requesters. The granted requester streams
// four signed 4-bit operands; the block sorts them ascending with a 6-comparator
// network and emits four 6-bit signed result beats chosen by the packet mode:
//   mode 0 : s1, s2, s3, s4           mode 1 : s4, s3, s2, s1
//   mode 2 : s1+s2, s2+s3, s3+s4, s4+s1
//   mode 3 : s1-s2, s2-s3, s4-s3, s4-s1
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : sort_arbiter_if.slave (requester handshakes, result stream,
//                busy flag)
// Parameter:
//   PRIO_INIT  : requester holding priority after reset (0=A, 1=B)
// Build option:
//   SORT_ARB_OUT_READY_EN : adds bus.out_ready; OUT advances only on
//                           out_valid && out_ready. Without it OUT advances
//                           every cycle.
// Timing: last input beat accepted in cycle T -> SORT in T+1 -> first result
// beat in T+2. Minimum packet period is 10 cycles (IDLE+4 LOAD+SORT+4 OUT).
// ----------------------------------------------------------------------------
module sort_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    sort_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

    // Compare-exchange pairs of the insertion-sort network (6 comparators).
    localparam int CMP_LO [6] = '{0, 1, 0, 2, 1, 0};
    localparam int CMP_HI [6] = '{1, 2, 1, 3, 2, 1};

    state_t            r_state;
    logic              r_grant;       // 0=A, 1=B
    logic              r_prio;        // round-robin priority holder
    logic        [1:0] r_beat;        // input beats received
    logic        [1:0] r_k;           // output beat index
    logic [3:0][3:0]   r_ops;         // shift register, [3] is the oldest beat
    logic        [1:0] r_mode;
    logic [3:0][5:0]   r_srt;         // sorted operands, [0] smallest
    logic              r_out_valid;
    logic signed [5:0] r_out_result;
    logic              r_out_id;

    logic              w_req_valid;
    logic        [3:0] w_req_number;
    logic        [1:0] w_req_mode;
    logic              w_xfer;
    logic              w_advance;
    logic [3:0][5:0]   w_net;

    // Granted requester's handshake; the other requester is never looked at
    // outside IDLE.
    assign w_req_valid  = r_grant ? bus.b_valid  : bus.a_valid;
    assign w_req_number = r_grant ? bus.b_number : bus.a_number;
    assign w_req_mode   = r_grant ? bus.b_mode   : bus.a_mode;
    assign w_xfer       = (r_state == LOAD) && w_req_valid;

    // Readies and busy are plain decodes of registered state.
    assign bus.a_ready  = (r_state == LOAD) && !r_grant;
    assign bus.b_ready  = (r_state == LOAD) &&  r_grant;
    assign bus.busy     = (r_state != IDLE);

    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_id     = r_out_id;

`ifdef SORT_ARB_OUT_READY_EN
    assign w_advance = bus.out_ready;
`else
    assign w_advance = 1'b1;
`endif

    // Sign-extend to 6 bits first so the network output feeds the adders
    // directly.
    always_comb begin
        logic [5:0] w_tmp;
        w_tmp = '0;
        for (int i = 0; i < 4; i++)
            w_net[i] = {{2{r_ops[i][3]}}, r_ops[i]};
        for (int c = 0; c < 6; c++) begin
            if ($signed(w_net[CMP_LO[c]]) > $signed(w_net[CMP_HI[c]])) begin
                w_tmp            = w_net[CMP_LO[c]];
                w_net[CMP_LO[c]] = w_net[CMP_HI[c]];
                w_net[CMP_HI[c]] = w_tmp;
            end
        end
    end

    // Result beat k of a packet from sorted operands s (s[0] smallest).
    // Operands are within -8..7, so sums and differences fit in 6 bits.
    function automatic logic signed [5:0] beat_val(input logic [1:0]     mode,
                                                   input logic [1:0]     k,
                                                   input logic [3:0][5:0] s);
        logic [1:0] kn;
        kn = k + 2'd1;          // wraps 3 -> 0 for the s4+s1 term
        case (mode)
            2'd0:    beat_val = $signed(s[k]);
            2'd1:    beat_val = $signed(s[2'd3 - k]);
            2'd2:    beat_val = $signed(s[k]) + $signed(s[kn]);
            default: begin
                case (k)
                    2'd0:    beat_val = $signed(s[0]) - $signed(s[1]);
                    2'd1:    beat_val = $signed(s[1]) - $signed(s[2]);
                    2'd2:    beat_val = $signed(s[3]) - $signed(s[2]);
                    default: beat_val = $signed(s[3]) - $signed(s[0]);
                endcase
            end
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_prio       <= PRIO_INIT;
            r_beat       <= '0;
            r_k          <= '0;
            r_ops        <= '0;
            r_mode       <= '0;
            r_srt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_id     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.a_valid || bus.b_valid) begin
                        // Contention goes to the priority holder.
                        r_grant <= (bus.a_valid && bus.b_valid) ? r_prio : bus.b_valid;
                        r_beat  <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // No timeout: a stalled requester just holds the count.
                    if (w_xfer) begin
                        r_ops  <= {r_ops[2:0], w_req_number};
                        if (r_beat == 2'd0)
                            r_mode <= w_req_mode;
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3)
                            r_state <= SORT;
                    end
                end
                SORT: begin
                    // First result beat is loaded here so out_valid rises
                    // exactly one cycle after SORT.
                    r_srt        <= w_net;
                    r_k          <= '0;
                    r_out_valid  <= 1'b1;
                    r_out_result <= beat_val(r_mode, 2'd0, w_net);
                    r_out_id     <= r_grant;
                    r_state      <= OUT;
                end
                OUT: begin
                    if (w_advance) begin
                        if (r_k == 2'd3) begin
                            r_out_valid  <= 1'b0;
                            r_out_result <= '0;
                            r_out_id     <= 1'b0;
                            r_prio       <= ~r_grant;
                            r_state      <= IDLE;
                        end else begin
                            r_k          <= r_k + 2'd1;
                            r_out_result <= beat_val(r_mode, r_k + 2'd1, r_srt);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_arbiter.sv
module tb_sort_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   tl, tf, ta, tb2, t1, t2, t3, t4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_arbiter_if bus();

    sort_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit b);
        return b ? bus.b_ready : bus.a_ready;
    endfunction

    task automatic drive(input bit b, input logic v, input logic [3:0] n, input logic [1:0] m);
        if (b) begin
            bus.b_valid = v; bus.b_number = n; bus.b_mode = m;
        end else begin
            bus.a_valid = v; bus.a_number = n; bus.a_mode = m;
        end
    endtask

    // Send four beats (first beat in d[15:12]); optional valid gap after beat 1.
    task automatic push(input bit b, input logic [15:0] d, input logic [1:0] m,
                        input int gap, output int t_last);
        bit ok;
        t_last = 0;
        for (int i = 0; i < 4; i++) begin
            drive(b, 1'b1, d[15-4*i -: 4], m);
            ok = 0;
            for (int w = 0; w < 60 && !ok; w++) begin
                @(negedge clk);
                if (rdy(b)) ok = 1;
            end
            chk("push_timeout", ok, 1);
            if (!ok) break;
            if (i == 3) t_last = cyc;
            @(posedge clk); #1;
            if (i == 1 && gap > 0) begin
                drive(b, 1'b0, d[15-4*i -: 4], m);
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_ready_hold", rdy(b), 1);
                end
                @(posedge clk); #1;
            end
        end
        drive(b, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic wait_out(output int t);
        bit ok;
        ok = 0;
        for (int w = 0; w < 60 && !ok; w++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1;
        end
        chk("out_timeout", ok, 1);
        t = cyc;
    endtask

    task automatic collect(input int e0, input int e1, input int e2, input int e3,
                           input bit id, input bit stall, output int t_first);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        wait_out(t_first);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("out_valid[%0d]", k), bus.out_valid, 1);
            chk($sformatf("out_result[%0d]", k), bus.out_result, e[k]);
            chk($sformatf("out_id[%0d]", k), bus.out_id, id);
            if (stall && k == 2) begin
`ifdef SORT_ARB_OUT_READY_EN
                bus.out_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_result", bus.out_result, e[k]);
                    chk("stall_id", bus.out_id, id);
                end
                bus.out_ready = 1'b1;
`endif
            end
        end
        @(negedge clk);
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_result", bus.out_result, 0);
        chk("idle_id", bus.out_id, 0);
    endtask

    // Structural checks on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_exclusive", bus.a_ready && bus.b_ready, 0);
            chk("ready_outside_load", !bus.busy && (bus.a_ready || bus.b_ready), 0);
        end
    end

    initial begin
        drive(1'b0, 1'b0, 4'd0, 2'd0);
        drive(1'b1, 1'b0, 4'd0, 2'd0);
`ifdef SORT_ARB_OUT_READY_EN
        bus.out_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        rst = 1'b0;

        // A only, mode 0: 3,-2,7,0 -> -2,0,3,7
        push(1'b0, 16'h3E70, 2'd0, 0, tl);
        collect(-2, 0, 3, 7, 1'b0, 1'b0, tf);
        chk("lat_a_m0", tf - tl, 2);

        // B only, modes 2, 3, 1
        push(1'b1, 16'h3E70, 2'd2, 0, tl);
        collect(-2, 3, 10, 5, 1'b1, 1'b0, tf);
        chk("lat_b_m2", tf - tl, 2);
        push(1'b1, 16'h3E70, 2'd3, 0, tl);
        collect(-2, -3, 4, 9, 1'b1, 1'b0, tf);
        chk("lat_b_m3", tf - tl, 2);
        push(1'b1, 16'h3E70, 2'd1, 0, tl);
        collect(7, 3, 0, -2, 1'b1, 1'b0, tf);
        chk("lat_b_m1", tf - tl, 2);

        // A with a 3-cycle valid gap after beat 1 (and out stall when enabled)
        push(1'b0, 16'h3E70, 2'd0, 3, tl);
        collect(-2, 0, 3, 7, 1'b0, 1'b1, tf);
        chk("lat_gap", tf - tl, 2);

        // B packet, reset during OUT beat 1; priority was B, reset returns it to A
        push(1'b1, 16'h3E70, 2'd0, 0, tl);
        wait_out(tf);
        @(negedge clk);
        chk("pre_rst_beat1", bus.out_result, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_result", bus.out_result, 0);
        chk("mid_rst_out_id", bus.out_id, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_a_ready", bus.a_ready, 0);
        chk("mid_rst_b_ready", bus.b_ready, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_beat", bus.out_valid, 0);
            chk("post_rst_idle", bus.busy, 0);
        end

        // Both requesting continuously: A, B, A, B at the 10-cycle period
        fork
            begin
                push(1'b0, 16'h3E70, 2'd0, 0, ta);
                push(1'b0, 16'h8888, 2'd2, 0, ta);
            end
            begin
                push(1'b1, 16'h87F5, 2'd3, 0, tb2);
                push(1'b1, 16'h7777, 2'd2, 0, tb2);
            end
            begin
                collect(-2, 0, 3, 7, 1'b0, 1'b0, t1);
                collect(-7, -6, 2, 15, 1'b1, 1'b0, t2);
                chk("rr_period_1", t2 - t1, 10);
                collect(-16, -16, -16, -16, 1'b0, 1'b0, t3);
                chk("rr_period_2", t3 - t2, 10);
                collect(14, 14, 14, 14, 1'b1, 1'b0, t4);
                chk("rr_period_3", t4 - t3, 10);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
